// File: rtl/epmp_mem_arb.sv
// epmp_mem_arb -- two-port arbiter in front of a single asynchronous memory.
//
// Port 0 (CPU) and port 1 (debug loader) issue single accesses. In IDLE one
// request is granted and its direction/address/data are latched. The memory
// strobe is then held for WAIT_CYC cycles (ACCESS). A one-cycle Ack follows
// on the granted port (DONE), and the FSM returns to IDLE.
//
// Configuration macro: EPMP_ARB_RR_EN
//   defined   : simultaneous requests are resolved round-robin using a
//               last-grant register (reset value 1, so port 0 wins first).
//   undefined : fixed priority, port 0 always wins.
//
// Ports:
//   clk               system clock, rising edge
//   Reset             asynchronous active-low reset
//   Req0/RnW0/Addr0/Wdata0   port 0 request, direction (1=read), address, write data
//   Req1/RnW1/Addr1/Wdata1   port 1, same meaning
//   Ack0, Ack1        one-cycle completion pulses
//   Rdata             read data, valid while Ack0/Ack1 is high
//   Mem_A, Mem_D_Out, Mem_D_Oe, Mem_D_In, Mem_Rd, Mem_Wr   memory side
//   Grant             index of the port owning the current access
//   Busy              high whenever the FSM is not in IDLE
//   Dbg_State         current FSM state (0=IDLE, 1=ACCESS, 2=DONE)
//
// Handshake: a port raises Req and holds it (with RnW/Addr/Wdata) until its
// Ack pulse. Inputs are sampled only at the IDLE edge that grants the
// request; a Req dropped afterwards does not cancel the access.

module epmp_mem_arb #(
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        RnW0,
    input  logic [15:0] Addr0,
    input  logic [7:0]  Wdata0,
    input  logic        Req1,
    input  logic        RnW1,
    input  logic [15:0] Addr1,
    input  logic [7:0]  Wdata1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [7:0]  Rdata,
    output logic [15:0] Mem_A,
    output logic [7:0]  Mem_D_Out,
    output logic        Mem_D_Oe,
    input  logic [7:0]  Mem_D_In,
    output logic        Mem_Rd,
    output logic        Mem_Wr,
    output logic        Grant,
    output logic        Busy,
    output logic [1:0]  Dbg_State
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        rnw_q, rnw_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        win;

`ifdef EPMP_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the port that did not win last time goes next.
    assign win = (Req0 && Req1) ? ~last_q : Req1;

    // Updated on every grant, including uncontested ones.
    assign last_d = (state_q == S_IDLE && (Req0 || Req1)) ? win : last_q;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: port 1 wins only when port 0 is not requesting.
    assign win = ~Req0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (Req0 || Req1) begin
                    grant_d = win;
                    rnw_d   = win ? RnW1   : RnW0;
                    addr_d  = win ? Addr1  : Addr0;
                    wdata_d = win ? Wdata1 : Wdata0;
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                    // Memory data is taken at the edge ending the strobe.
                    if (rnw_q) begin
                        rdata_d = Mem_D_In;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            grant_q <= 1'b0;
            rnw_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes are decoded from registered state only, so reset clears them
    // immediately without waiting for a clock.
    assign Mem_Rd    = (state_q == S_ACCESS) &&  rnw_q;
    assign Mem_Wr    = (state_q == S_ACCESS) && !rnw_q;
    assign Mem_D_Oe  = (state_q == S_ACCESS) && !rnw_q;
    assign Mem_A     = addr_q;
    assign Mem_D_Out = wdata_q;
    assign Ack0      = (state_q == S_DONE) && !grant_q;
    assign Ack1      = (state_q == S_DONE) &&  grant_q;
    assign Rdata     = rdata_q;
    assign Grant     = grant_q;
    assign Busy      = (state_q != S_IDLE);
    assign Dbg_State = state_q;

endmodule

// File: tb/tb_epmp_mem_arb.sv
module tb_epmp_mem_arb;

  localparam int W = 2;

  typedef struct packed {
    logic        done;
    logic        last;
    logic        grant;
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 0, rnw0 = 0, req1 = 0, rnw1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0, mem_d_in = 0;
  logic ack0, ack1, mem_d_oe, mem_rd, mem_wr, grant, busy;
  logic [7:0] rdata, mem_d_out;
  logic [15:0] mem_a;
  logic [1:0] dbg_state;

  // second instance, WAIT_CYC=1
  logic b_req1 = 0;
  logic b_ack0, b_ack1, b_oe, b_rd, b_wr, b_grant, b_busy;
  logic [7:0] b_rdata, b_dout;
  logic [15:0] b_a;
  logic [1:0] b_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  ent_t exp_q[$];
  logic [7:0] exp_rdata = 8'h00;
  logic m_last = 1'b1;

  epmp_mem_arb #(.WAIT_CYC(W)) u_dut (
    .clk(clk), .Reset(rst_n),
    .Req0(req0), .RnW0(rnw0), .Addr0(addr0), .Wdata0(wdata0),
    .Req1(req1), .RnW1(rnw1), .Addr1(addr1), .Wdata1(wdata1),
    .Ack0(ack0), .Ack1(ack1), .Rdata(rdata), .Mem_A(mem_a),
    .Mem_D_Out(mem_d_out), .Mem_D_Oe(mem_d_oe), .Mem_D_In(mem_d_in),
    .Mem_Rd(mem_rd), .Mem_Wr(mem_wr), .Grant(grant), .Busy(busy),
    .Dbg_State(dbg_state)
  );

  epmp_mem_arb #(.WAIT_CYC(1)) u_w1 (
    .clk(clk), .Reset(rst_n),
    .Req0(1'b0), .RnW0(1'b0), .Addr0(16'h0000), .Wdata0(8'h00),
    .Req1(b_req1), .RnW1(1'b0), .Addr1(16'h0042), .Wdata1(8'h11),
    .Ack0(b_ack0), .Ack1(b_ack1), .Rdata(b_rdata), .Mem_A(b_a),
    .Mem_D_Out(b_dout), .Mem_D_Oe(b_oe), .Mem_D_In(8'h00),
    .Mem_Rd(b_rd), .Mem_Wr(b_wr), .Grant(b_grant), .Busy(b_busy),
    .Dbg_State(b_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a granted request becomes a schedule of W
  // strobe cycles followed by one ack cycle; an empty schedule means idle.
  initial begin
    ent_t e;
    logic w;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        exp_rdata = 8'h00;
        m_last = 1'b1;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.last && e.rnw) exp_rdata = mem_d_in;
      end else if (req0 || req1) begin
`ifdef EPMP_ARB_RR_EN
        if (req0 && req1) w = (m_last == 1'b0) ? 1'b1 : 1'b0;
        else w = req1;
        m_last = w;
`else
        w = req0 ? 1'b0 : 1'b1;
`endif
        for (int k = 0; k < W; k++) begin
          e.done = 1'b0;
          e.last = (k == W - 1);
          e.grant = w;
          e.rnw = w ? rnw1 : rnw0;
          e.addr = w ? addr1 : addr0;
          e.wdata = w ? wdata1 : wdata0;
          exp_q.push_back(e);
        end
        e.done = 1'b1;
        e.last = 1'b0;
        exp_q.push_back(e);
      end
    end
  end

  // compare process: every cycle out of reset
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() == 0) begin
          chk("idle_busy", busy, 0);
          chk("idle_strobes", {mem_rd, mem_wr, mem_d_oe}, 0);
          chk("idle_acks", {ack0, ack1}, 0);
        end else begin
          e = exp_q[0];
          chk("busy", busy, 1);
          chk("grant", grant, e.grant);
          if (!e.done) begin
            chk("mem_rd", mem_rd, e.rnw);
            chk("mem_wr", mem_wr, !e.rnw);
            chk("mem_oe", mem_d_oe, !e.rnw);
            chk("mem_a", mem_a, e.addr);
            chk("mem_dout", mem_d_out, e.wdata);
            chk("acc_acks", {ack0, ack1}, 0);
          end else begin
            chk("done_strobes", {mem_rd, mem_wr, mem_d_oe}, 0);
            chk("ack0", ack0, !e.grant);
            chk("ack1", ack1, e.grant);
            if (e.rnw) chk("rdata", rdata, exp_rdata);
          end
        end
      end
    end
  end

  // stimulus with hand-computed literal expectations
  initial begin
    logic [1:0] g[4];
    logic [1:0] ge[4];
    int ack_cyc[$];

    // reset state (before any clock edge is acted on)
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_a", mem_a, 16'h0000);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_dout", mem_d_out, 8'h00);
    chk("rst_strobes", {mem_rd, mem_wr, mem_d_oe}, 0);
    chk("rst_acks", {ack0, ack1}, 0);
    chk("rst_grant", grant, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // read 0x1234 on port 0
    @(negedge clk);
    req0 = 1; rnw0 = 1; addr0 = 16'h1234; mem_d_in = 8'hA5;
    @(negedge clk);
    chk("t1_rd1", mem_rd, 1);
    chk("t1_a", mem_a, 16'h1234);
    @(negedge clk);
    chk("t1_rd2", mem_rd, 1);
    chk("t1_early_ack", ack0, 0);
    @(negedge clk);
    chk("t1_ack0", ack0, 1);
    chk("t1_rdata", rdata, 8'hA5);
    chk("t1_rd_off", mem_rd, 0);
    req0 = 0;
    @(negedge clk);

    // write 0x5A to 0x8000 on port 1
    req1 = 1; rnw1 = 0; addr1 = 16'h8000; wdata1 = 8'h5A;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("t2_wr_oe", {mem_wr, mem_d_oe}, 2'b11);
      chk("t2_dout", mem_d_out, 8'h5A);
      chk("t2_a", mem_a, 16'h8000);
    end
    @(negedge clk);
    chk("t2_ack", {ack0, ack1}, 2'b01);
    req1 = 0;
    @(negedge clk);
    chk("t2_idle", busy, 0);

    // contention: both ports held for four accesses
    req0 = 1; rnw0 = 0; addr0 = 16'h0100; wdata0 = 8'h01;
    req1 = 1; rnw1 = 0; addr1 = 16'h0200; wdata1 = 8'h02;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      g[i] = {1'b0, grant};
      if (i < 3) repeat (W + 2) @(negedge clk);
      else repeat (W) @(negedge clk);
    end
    req0 = 0; req1 = 0;
`ifdef EPMP_ARB_RR_EN
    ge[0] = 0; ge[1] = 1; ge[2] = 0; ge[3] = 1;
`else
    ge[0] = 0; ge[1] = 0; ge[2] = 0; ge[3] = 0;
`endif
    for (int i = 0; i < 4; i++) chk("t3_grant_seq", g[i], ge[i]);
    @(negedge clk);

    // reset in the second ACCESS cycle, pending Req0 served afterwards
    req0 = 1; rnw0 = 1; addr0 = 16'h4242; mem_d_in = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    chk("t4_rd_before", mem_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_strobes", {mem_rd, mem_wr, mem_d_oe}, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_a", mem_a, 16'h0000);
    chk("t4_rst_rdata", rdata, 8'h00);
    @(negedge clk);
    chk("t4_no_ack", {ack0, ack1}, 0);
    #2 rst_n = 1'b1;
    repeat (W + 1) @(negedge clk);
    chk("t4_ack0", ack0, 1);
    chk("t4_rdata", rdata, 8'h3C);
    req0 = 0;
    @(negedge clk);

    // Req0 dropped one cycle after grant
    req0 = 1; rnw0 = 0; addr0 = 16'h0777; wdata0 = 8'hC3;
    @(negedge clk);
    req0 = 0;
    repeat (W) @(negedge clk);
    chk("t5_ack0", ack0, 1);
    @(negedge clk);
    chk("t5_busy", busy, 0);

    // randomized traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      rnw0 = $urandom_range(0, 1);
      rnw1 = $urandom_range(0, 1);
      addr0 = 16'($urandom);
      addr1 = 16'($urandom);
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      mem_d_in = 8'($urandom);
      @(negedge clk);
    end
    req0 = 0; req1 = 0;
    repeat (W + 3) @(negedge clk);

    // WAIT_CYC=1 back-to-back Req1: acks every 3 cycles
    b_req1 = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_ack1) ack_cyc.push_back(cyc);
      chk("w1_no_ack0", b_ack0, 0);
    end
    b_req1 = 0;
    chk("w1_ack_count_ge3", (ack_cyc.size() >= 3), 1);
    if (ack_cyc.size() >= 3) begin
      chk("w1_spacing_a", ack_cyc[1] - ack_cyc[0], 3);
      chk("w1_spacing_b", ack_cyc[2] - ack_cyc[1], 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/epmp_mem_arb.md
EPMP_MEM_ARB -- requirements
Module: epmp_mem_arb

Interface
REQ-001 The block SHALL have parameter WAIT_CYC, default 2: number of cycles the memory strobe is held per access, legal range 1..15.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Req0  input  1  port 0 (CPU) access request; held high until Ack0.
REQ-005 RnW0  input  1  port 0 direction: 1 = read, 0 = write.
REQ-006 Addr0  input  16  port 0 address.
REQ-007 Wdata0  input  8  port 0 write data.
REQ-008 Req1, RnW1, Addr1, Wdata1  input  1/1/16/8  port 1 (debug loader) request, direction, address and write data, with the same meaning as port 0.
REQ-009 Ack0, Ack1  output  1 each  one-cycle completion pulse per port.
REQ-010 Rdata  output  8  read data; valid while Ack0 or Ack1 is high.
REQ-011 Mem_A  output  16  memory address.
REQ-012 Mem_D_Out  output  8  write data to memory.
REQ-013 Mem_D_Oe  output  1  memory data-bus drive enable.
REQ-014 Mem_D_In  input  8  read data from memory.
REQ-015 Mem_Rd, Mem_Wr  output  1 each  active-high memory strobes.
REQ-016 Grant  output  1  index of the port owning the current access.
REQ-017 Busy  output  1  high in states other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-019 In IDLE with any Req high, the block SHALL latch the winning port's Grant, RnW, Addr and Wdata at the clock edge and enter ACCESS.
REQ-020 ACCESS SHALL last exactly WAIT_CYC cycles, counted by a 4-bit counter.
REQ-021 During ACCESS, Mem_A SHALL equal the latched address; Mem_Rd SHALL equal latched RnW; Mem_Wr and Mem_D_Oe SHALL equal NOT latched RnW; Mem_D_Out SHALL equal the latched write data.
REQ-022 On a read, Mem_D_In SHALL be captured into Rdata at the edge that ends the last ACCESS cycle.
REQ-023 In DONE, the block SHALL pulse Ack of the granted port for exactly one cycle, with all memory strobes low, and then return unconditionally to IDLE.
REQ-024 Latency: from Req sampled in IDLE to Ack high SHALL be WAIT_CYC+1 cycles; minimum request-to-request spacing SHALL be WAIT_CYC+2 cycles.
REQ-025 Outside ACCESS, Mem_Rd, Mem_Wr and Mem_D_Oe SHALL be 0.
REQ-026 Inputs SHALL be ignored after latching; a Req dropped mid-access SHALL NOT abort the access, and the Ack SHALL still be issued.
REQ-027 Arbitration occurs only in IDLE; a request arriving during ACCESS/DONE SHALL wait for IDLE.
REQ-028 Outside DONE, Ack0 and Ack1 SHALL be 0; the two SHALL never be high together.

Reset
REQ-029 Asserting Reset SHALL immediately, without clk, force: state IDLE, counter 0, Grant 0, last-grant register 1, Busy 0, Ack0/Ack1 0, Rdata 0x00, Mem_A 0x0000, Mem_D_Out 0x00, Mem_Rd/Mem_Wr/Mem_D_Oe 0.
REQ-030 Reset mid-access SHALL abort the access with no Ack; after Reset releases, the first clock edge SHALL behave as IDLE.

Configuration
REQ-031 With macro EPMP_ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin: the port not recorded in the last-grant register wins, and the last-grant register updates on every grant.
REQ-032 Without EPMP_ARB_RR_EN, fixed priority SHALL apply: port 0 always wins, and the last-grant register is absent or unused.

Verification
REQ-033 WAIT_CYC=2, Req0 read of 0x1234, Mem_D_In=0xA5 -> Mem_Rd high for 2 cycles with Mem_A=0x1234; Ack0 pulses at cycle 3 with Rdata=0xA5.
REQ-034 Req1 write of 0x5A to 0x8000 -> Mem_Wr=1, Mem_D_Oe=1, Mem_D_Out=0x5A for WAIT_CYC cycles; Ack1 pulses once; Ack0 stays 0.
REQ-035 Req0 and Req1 held high together for 4 accesses -> with EPMP_ARB_RR_EN, grants are 0,1,0,1; without it, grants are 0,0,0,0.
REQ-036 Reset asserted in the 2nd ACCESS cycle -> strobes drop before the next edge, no Ack is issued, and after release a pending Req0 is served normally.
REQ-037 Req0 dropped one cycle after grant -> access completes and Ack0 still pulses; the block returns to IDLE with Busy=0.
REQ-038 WAIT_CYC=1 back-to-back Req1 -> Ack1 spacing is exactly 3 cycles.
